// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_duty_decoder
// Purpose  : Samples an asynchronous 1 MHz-domain PWM line and measures its
//            period and high time. Reports the duty cycle and a quantised
//            power level (0/25/50/75/100 %). A stalled line is reported as
//            0 % or 100 %, and an out-of-tolerance period raises a flag.
// Ports    : clk_1mhz   - 1 MHz system clock
//            reset      - asynchronous, active-high reset
//            pwm_in     - PWM line, asynchronous to clk_1mhz
//            duty_valid - one-cycle pulse when duty_pct/level are updated
//            duty_pct   - high cycles per nominal period, clamped to 0..100
//            level      - 0=0 %, 1=25 %, 2=50 %, 3=75 %, 4=100 %
//            period_err - one-cycle pulse on an out-of-tolerance period
//            pwm_active - high while valid periods are being tracked
// Options  : PWM_DUTY_FILTER_EN - level changes only after two consecutive
//            valid periods agree on the same new level
// Revision : 1.0 - initial release
// ============================================================================
module pwm_duty_decoder #(
  parameter int PERIOD_US  = 100,
  parameter int PERIOD_TOL = 2,
  parameter int TIMEOUT_US = 250,
  parameter int CNT_W      = 9
) (
  input  logic       clk_1mhz,
  input  logic       reset,
  input  logic       pwm_in,
  output logic       duty_valid,
  output logic [7:0] duty_pct,
  output logic [2:0] level,
  output logic       period_err,
  output logic       pwm_active
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ARMED = 2'd1;
  localparam logic [1:0] c_TRACK = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] c_PER_MIN  = CNT_W'(PERIOD_US - PERIOD_TOL);
  localparam logic [CNT_W-1:0] c_PER_MAX  = CNT_W'(PERIOD_US + PERIOD_TOL);
  localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] c_DUTY_MAX = CNT_W'(100);

  logic             r_s1;
  logic             r_s2;
  logic             r_prev;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  logic             w_rise;
  logic             w_per_ok;
  logic             w_timeout;
  logic [7:0]       w_duty_meas;
  logic [2:0]       w_meas_lvl;

  logic             w_valid_nxt;
  logic             w_err_nxt;
  logic             w_active_nxt;
  logic [7:0]       w_pct_nxt;
  logic [2:0]       w_lvl_nxt;

`ifdef PWM_DUTY_FILTER_EN
  logic [2:0]       r_cand;
  logic             r_cand_vld;
  logic [2:0]       w_cand_nxt;
  logic             w_cand_vld_nxt;
`endif

  function automatic logic [2:0] f_quant(input logic [7:0] pct);
    if (pct < 8'd13)      return 3'd0;
    else if (pct < 8'd38) return 3'd1;
    else if (pct < 8'd63) return 3'd2;
    else if (pct < 8'd88) return 3'd3;
    else                  return 3'd4;
  endfunction

  // Input synchroniser followed by a one-cycle delayed copy for edge detect.
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= pwm_in;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_rise      = r_s2 & ~r_prev;
  assign w_per_ok    = (r_per_cnt >= c_PER_MIN) && (r_per_cnt <= c_PER_MAX);
  assign w_timeout   = (r_per_cnt >= c_TIMEOUT);
  // Periods slightly longer than nominal can carry more than 100 high cycles.
  assign w_duty_meas = (r_hi_cnt > c_DUTY_MAX) ? 8'd100 : 8'(r_hi_cnt);
  assign w_meas_lvl  = f_quant(w_duty_meas);

  // The rise cycle itself is the first cycle of the new period (and is high),
  // so both counters restart at 1 rather than 0. Both saturate so a stalled
  // line never wraps back into the valid window.
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (w_rise) begin
      r_per_cnt <= CNT_W'(1);
      r_hi_cnt  <= CNT_W'(1);
    end else begin
      if (r_per_cnt != c_CNT_MAX) r_per_cnt <= r_per_cnt + 1'b1;
      if (r_s2 && (r_hi_cnt != c_CNT_MAX)) r_hi_cnt <= r_hi_cnt + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state. A rise always wins over a coincident timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_rise) w_state_nxt = c_ARMED;
      end
      c_ARMED, c_TRACK: begin
        if (w_rise)         w_state_nxt = w_per_ok ? c_TRACK : c_ARMED;
        else if (w_timeout) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM: output decode into next values of the registered outputs.
  always_comb begin
    w_valid_nxt  = 1'b0;
    w_err_nxt    = 1'b0;
    w_active_nxt = pwm_active;
    w_pct_nxt    = duty_pct;
    w_lvl_nxt    = level;
`ifdef PWM_DUTY_FILTER_EN
    w_cand_nxt     = r_cand;
    w_cand_vld_nxt = r_cand_vld;
`endif
    if (r_state != c_IDLE) begin
      if (w_rise) begin
        if (w_per_ok) begin
          w_active_nxt = 1'b1;
`ifdef PWM_DUTY_FILTER_EN
          if (w_meas_lvl == level) begin
            // Back at the current level: any pending change is abandoned.
            w_cand_vld_nxt = 1'b0;
          end else if (r_cand_vld && (r_cand == w_meas_lvl)) begin
            w_pct_nxt      = w_duty_meas;
            w_lvl_nxt      = w_meas_lvl;
            w_valid_nxt    = 1'b1;
            w_cand_vld_nxt = 1'b0;
          end else begin
            w_cand_nxt     = w_meas_lvl;
            w_cand_vld_nxt = 1'b1;
          end
`else
          w_pct_nxt   = w_duty_meas;
          w_lvl_nxt   = w_meas_lvl;
          w_valid_nxt = 1'b1;
`endif
        end else begin
          w_err_nxt    = 1'b1;
          w_active_nxt = 1'b0;
`ifdef PWM_DUTY_FILTER_EN
          w_cand_vld_nxt = 1'b0;
`endif
        end
      end else if (w_timeout) begin
        // Stalled line: report the level it is stuck at.
        w_pct_nxt    = r_s2 ? 8'd100 : 8'd0;
        w_lvl_nxt    = r_s2 ? 3'd4 : 3'd0;
        w_valid_nxt  = 1'b1;
        w_active_nxt = 1'b0;
`ifdef PWM_DUTY_FILTER_EN
        w_cand_vld_nxt = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      duty_valid <= 1'b0;
      duty_pct   <= 8'd0;
      level      <= 3'd0;
      period_err <= 1'b0;
      pwm_active <= 1'b0;
    end else begin
      duty_valid <= w_valid_nxt;
      duty_pct   <= w_pct_nxt;
      level      <= w_lvl_nxt;
      period_err <= w_err_nxt;
      pwm_active <= w_active_nxt;
    end
  end

`ifdef PWM_DUTY_FILTER_EN
  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      r_cand     <= 3'd0;
      r_cand_vld <= 1'b0;
    end else begin
      r_cand     <= w_cand_nxt;
      r_cand_vld <= w_cand_vld_nxt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_duty_decoder
// Purpose  : Directed self-checking bench for pwm_duty_decoder
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_decoder;

  logic       clk_1mhz = 1'b0;
  logic       reset    = 1'b1;
  logic       pwm_in   = 1'b0;
  logic       duty_valid;
  logic [7:0] duty_pct;
  logic [2:0] level;
  logic       period_err;
  logic       pwm_active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_rise = 0;

  // Running totals recorded by the monitor; tests work on differences.
  int         tot_valid = 0;
  int         tot_err   = 0;
  int         tot_lvl [5];
  int         q_pulse [$];
  logic [7:0] cap_pct = 8'd0;
  logic [2:0] cap_lvl = 3'd0;

  pwm_duty_decoder dut (
    .clk_1mhz   (clk_1mhz),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_valid (duty_valid),
    .duty_pct   (duty_pct),
    .level      (level),
    .period_err (period_err),
    .pwm_active (pwm_active)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  always @(posedge clk_1mhz) cyc <= cyc + 1;

  always @(negedge clk_1mhz) begin
    if (duty_valid === 1'b1) begin
      tot_valid++;
      if (level <= 3'd4) tot_lvl[level]++;
      q_pulse.push_back(cyc);
      cap_pct = duty_pct;
      cap_lvl = level;
    end
    if (period_err === 1'b1) tot_err++;
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      @(posedge clk_1mhz);
      #1;
    end
  endtask

  // One PWM period: 'hi' cycles high then low up to 'tot'; records the
  // cycle count of its first (rising) edge.
  task automatic period(input int hi, input int tot);
    pwm_in = 1'b1;
    @(posedge clk_1mhz);
    #1;
    last_rise = cyc;
    drive(1'b1, hi - 1);
    drive(1'b0, tot - hi);
  endtask

  task automatic do_reset;
    reset  = 1'b1;
    pwm_in = 1'b0;
    drive(1'b0, 3);
    reset = 1'b0;
    drive(1'b0, 3);
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    pwm_in = 1'b0;
    drive(1'b1, 4);
    drive(1'b0, 2);
    total++; if (duty_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", duty_valid); end
    total++; if (duty_pct !== 8'd0) begin bad++; $display("FAIL reset_pct: got %0d want 0", duty_pct); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (period_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", period_err); end
    total++; if (pwm_active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", pwm_active); end
    reset = 1'b0;
    drive(1'b0, 3);
  endtask

  task automatic test_stall_high;
    int bv, be, r, lat;
    do_reset;
    bv = tot_valid; be = tot_err;
    drive(1'b0, 300);
    total++; if (tot_valid - bv !== 0) begin bad++; $display("FAIL idle_low_quiet: got %0d pulses want 0", tot_valid - bv); end
    period(300, 300);
    r   = last_rise;
    lat = (q_pulse.size() > bv) ? q_pulse[bv] - r : -1;
    total++; if (tot_valid - bv !== 1) begin bad++; $display("FAIL stall_count: got %0d want 1", tot_valid - bv); end
    total++; if (lat !== 252) begin bad++; $display("FAIL stall_latency: got %0d want 252", lat); end
    total++; if (duty_pct !== 8'd100) begin bad++; $display("FAIL stall_pct: got %0d want 100", duty_pct); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL stall_level: got %0d want 4", level); end
    total++; if (pwm_active !== 1'b0) begin bad++; $display("FAIL stall_active: got %b want 0", pwm_active); end
    // Back in IDLE, the next rise only re-arms: no error and no update.
    drive(1'b0, 50);
    period(50, 100);
    total++; if (tot_err - be !== 0) begin bad++; $display("FAIL stall_rearm_err: got %0d want 0", tot_err - be); end
    total++; if (tot_valid - bv !== 1) begin bad++; $display("FAIL stall_rearm_valid: got %0d want 1", tot_valid - bv); end
  endtask

`ifdef PWM_DUTY_FILTER_EN
  task automatic test_filter;
    int bv;
    do_reset;
    bv = tot_valid;
    for (int i = 0; i < 3; i++) period(75, 100);
    period(25, 100);
    period(75, 100);
    drive(1'b1, 5);
    total++; if (tot_valid - bv !== 1) begin bad++; $display("FAIL filt_single_count: got %0d want 1", tot_valid - bv); end
    total++; if (level !== 3'd3) begin bad++; $display("FAIL filt_single_level: got %0d want 3", level); end
    total++; if (duty_pct !== 8'd75) begin bad++; $display("FAIL filt_single_pct: got %0d want 75", duty_pct); end
    drive(1'b1, 70);
    drive(1'b0, 25);
    period(25, 100);
    period(25, 100);
    drive(1'b1, 5);
    total++; if (tot_valid - bv !== 2) begin bad++; $display("FAIL filt_double_count: got %0d want 2", tot_valid - bv); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL filt_double_level: got %0d want 1", level); end
    total++; if (duty_pct !== 8'd25) begin bad++; $display("FAIL filt_double_pct: got %0d want 25", duty_pct); end
  endtask
`else
  task automatic test_steady;
    int bv, be, r2, first, gap;
    do_reset;
    bv = tot_valid; be = tot_err;
    period(75, 100);
    total++; if (tot_valid - bv !== 0) begin bad++; $display("FAIL steady_first_rise: got %0d pulses want 0", tot_valid - bv); end
    period(75, 100);
    r2 = last_rise;
    for (int i = 0; i < 4; i++) period(75, 100);
    drive(1'b1, 5);
    first = (q_pulse.size() > bv) ? q_pulse[bv] - r2 : -1;
    gap   = (q_pulse.size() > bv + 5) ? q_pulse[bv + 5] - q_pulse[bv + 4] : -1;
    total++; if (tot_valid - bv !== 6) begin bad++; $display("FAIL steady_count: got %0d want 6", tot_valid - bv); end
    total++; if (first !== 2) begin bad++; $display("FAIL steady_latency: got %0d want 2", first); end
    total++; if (gap !== 100) begin bad++; $display("FAIL steady_interval: got %0d want 100", gap); end
    total++; if (duty_pct !== 8'd75) begin bad++; $display("FAIL steady_pct: got %0d want 75", duty_pct); end
    total++; if (level !== 3'd3) begin bad++; $display("FAIL steady_level: got %0d want 3", level); end
    total++; if (pwm_active !== 1'b1) begin bad++; $display("FAIL steady_active: got %b want 1", pwm_active); end
    total++; if (tot_err - be !== 0) begin bad++; $display("FAIL steady_err: got %0d want 0", tot_err - be); end
  endtask

  task automatic test_quant;
    int         hi_t  [11] = '{50, 12, 13, 37, 38, 62, 63, 87, 88, 99, 101};
    int         tot_t [11] = '{100, 100, 100, 100, 100, 100, 100, 100, 100, 100, 102};
    int         pct_t [11] = '{50, 12, 13, 37, 38, 62, 63, 87, 88, 99, 100};
    logic [2:0] lvl_t [11] = '{3'd2, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4};
    int bv;
    do_reset;
    bv = tot_valid;
    for (int i = 0; i < 11; i++) begin
      period(hi_t[i], tot_t[i]);
      if (i > 0) begin
        total++; if (tot_valid - bv !== i) begin bad++; $display("FAIL quant_count[%0d]: got %0d want %0d", i - 1, tot_valid - bv, i); end
        total++; if (cap_pct !== 8'(pct_t[i-1])) begin bad++; $display("FAIL quant_pct[%0d]: got %0d want %0d", i - 1, cap_pct, pct_t[i-1]); end
        total++; if (cap_lvl !== lvl_t[i-1]) begin bad++; $display("FAIL quant_level[%0d]: got %0d want %0d", i - 1, cap_lvl, lvl_t[i-1]); end
      end
    end
    drive(1'b1, 5);
    total++; if (cap_pct !== 8'd100) begin bad++; $display("FAIL quant_clamp_pct: got %0d want 100", cap_pct); end
    total++; if (cap_lvl !== 3'd4) begin bad++; $display("FAIL quant_clamp_level: got %0d want 4", cap_lvl); end
  endtask

  task automatic test_ramp_timeout;
    int bv, b0, b1, b2, b3, lat;
    do_reset;
    bv = tot_valid;
    b0 = tot_lvl[0]; b1 = tot_lvl[1]; b2 = tot_lvl[2]; b3 = tot_lvl[3];
    for (int i = 0; i < 33; i++) period(75, 100);
    for (int i = 0; i < 33; i++) period(50, 100);
    for (int i = 0; i < 33; i++) period(25, 100);
    drive(1'b0, 200);
    lat = (q_pulse.size() > 0) ? q_pulse[q_pulse.size() - 1] - last_rise : -1;
    total++; if (tot_lvl[3] - b3 !== 33) begin bad++; $display("FAIL ramp_lvl3: got %0d want 33", tot_lvl[3] - b3); end
    total++; if (tot_lvl[2] - b2 !== 33) begin bad++; $display("FAIL ramp_lvl2: got %0d want 33", tot_lvl[2] - b2); end
    total++; if (tot_lvl[1] - b1 !== 32) begin bad++; $display("FAIL ramp_lvl1: got %0d want 32", tot_lvl[1] - b1); end
    total++; if (tot_lvl[0] - b0 !== 1) begin bad++; $display("FAIL ramp_lvl0: got %0d want 1", tot_lvl[0] - b0); end
    total++; if (tot_valid - bv !== 99) begin bad++; $display("FAIL ramp_count: got %0d want 99", tot_valid - bv); end
    total++; if (lat !== 252) begin bad++; $display("FAIL ramp_timeout_latency: got %0d want 252", lat); end
    total++; if (duty_pct !== 8'd0) begin bad++; $display("FAIL ramp_timeout_pct: got %0d want 0", duty_pct); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL ramp_timeout_level: got %0d want 0", level); end
    total++; if (pwm_active !== 1'b0) begin bad++; $display("FAIL ramp_timeout_active: got %b want 0", pwm_active); end
  endtask

  task automatic test_period_err;
    int bv, be;
    do_reset;
    bv = tot_valid; be = tot_err;
    for (int i = 0; i < 3; i++) period(50, 100);
    period(50, 120);
    drive(1'b1, 5);
    total++; if (tot_err - be !== 1) begin bad++; $display("FAIL perr_120_err: got %0d want 1", tot_err - be); end
    total++; if (tot_valid - bv !== 3) begin bad++; $display("FAIL perr_120_valid: got %0d want 3", tot_valid - bv); end
    total++; if (pwm_active !== 1'b0) begin bad++; $display("FAIL perr_120_active: got %b want 0", pwm_active); end
    total++; if (duty_pct !== 8'd50) begin bad++; $display("FAIL perr_120_hold: got %0d want 50", duty_pct); end
    drive(1'b1, 45);
    drive(1'b0, 50);
    period(50, 98);
    period(50, 102);
    drive(1'b1, 5);
    total++; if (tot_valid - bv !== 6) begin bad++; $display("FAIL perr_tol_valid: got %0d want 6", tot_valid - bv); end
    total++; if (tot_err - be !== 1) begin bad++; $display("FAIL perr_tol_err: got %0d want 1", tot_err - be); end
    total++; if (duty_pct !== 8'd50) begin bad++; $display("FAIL perr_tol_pct: got %0d want 50", duty_pct); end
    total++; if (level !== 3'd2) begin bad++; $display("FAIL perr_tol_level: got %0d want 2", level); end
    total++; if (pwm_active !== 1'b1) begin bad++; $display("FAIL perr_tol_active: got %b want 1", pwm_active); end
    drive(1'b1, 45);
    drive(1'b0, 47);
    drive(1'b1, 5);
    total++; if (tot_err - be !== 2) begin bad++; $display("FAIL perr_97_err: got %0d want 2", tot_err - be); end
    total++; if (tot_valid - bv !== 6) begin bad++; $display("FAIL perr_97_valid: got %0d want 6", tot_valid - bv); end
  endtask

  task automatic test_reset_mid;
    int bv;
    do_reset;
    for (int i = 0; i < 3; i++) period(75, 100);
    drive(1'b1, 40);
    #2;
    reset = 1'b1;
    #1;
    total++; if (duty_pct !== 8'd0) begin bad++; $display("FAIL rmid_pct: got %0d want 0", duty_pct); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    total++; if (pwm_active !== 1'b0) begin bad++; $display("FAIL rmid_active: got %b want 0", pwm_active); end
    drive(1'b1, 35);
    drive(1'b0, 10);
    reset = 1'b0;
    drive(1'b0, 15);
    bv = tot_valid;
    period(75, 100);
    total++; if (tot_valid - bv !== 0) begin bad++; $display("FAIL rmid_first_rise: got %0d pulses want 0", tot_valid - bv); end
    drive(1'b1, 5);
    total++; if (tot_valid - bv !== 1) begin bad++; $display("FAIL rmid_second_rise: got %0d pulses want 1", tot_valid - bv); end
    total++; if (duty_pct !== 8'd75) begin bad++; $display("FAIL rmid_pct_after: got %0d want 75", duty_pct); end
  endtask
`endif

  initial begin
    test_reset;
`ifdef PWM_DUTY_FILTER_EN
    test_stall_high;
    test_filter;
`else
    test_steady;
    test_quant;
    test_ramp_timeout;
    test_stall_high;
    test_period_err;
    test_reset_mid;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive-side counterpart to the team's PWM motor-drive generators: samples a PWM line running at 1 MHz, measures period and high time, and reports duty cycle plus a quantised power level (0/25/50/75/100 %).
- Used for closed-loop checking of the drive ramp and for decoding PWM commands from another board.
- Detects stalled lines (constant high or low), reports them as 100 % or 0 %, and flags malformed periods.

Parameters:
- PERIOD_US, 100: nominal PWM period in clk_1mhz cycles.
- PERIOD_TOL, 2: accepted deviation of the measured period, ± cycles.
- TIMEOUT_US, 250: cycles without a rising edge before the line is declared stalled; must exceed PERIOD_US+PERIOD_TOL.
- CNT_W, 9: counter width; must hold TIMEOUT_US.

Ports:
- clk_1mhz, input, 1: 1 MHz system clock.
- reset, input, 1: asynchronous, active-high reset.
- pwm_in, input, 1: PWM line, asynchronous to clk_1mhz.
- duty_valid, output, 1: one-cycle pulse when duty_pct and level are updated.
- duty_pct, output, 8: measured high cycles scaled to the nominal period (0..100).
- level, output, 3: quantised level, 0=0 %, 1=25 %, 2=50 %, 3=75 %, 4=100 %.
- period_err, output, 1: one-cycle pulse when a measured period is out of tolerance.
- pwm_active, output, 1: high while valid periods are being tracked.

Behaviour:
- Reset values:
  - Async assert clears all state.
  - duty_valid=0, duty_pct=0, level=0, period_err=0, pwm_active=0.
  - Synchroniser flops=0, FSM in IDLE.
- Input path:
  - 2-flop synchroniser (s1→s2), then prev register.
  - rise = s2 & ~prev.
  - If pwm_in is first sampled high at edge N, rise is true in the cycle after edge N+1, and outputs update at edge N+2.
- Counters:
  - On a rise cycle: per_cnt←1 and hi_cnt←1.
  - Otherwise per_cnt increments saturating at 2^CNT_W−1, and hi_cnt increments when s2=1.
  - A clean 100-cycle period with 75 high cycles measures per=100, hi=75.
- FSM:
  - IDLE: on rise → ARMED. No valid pulse is produced, because the first edge only starts a measurement.
  - ARMED / TRACK on rise:
    - If |per_cnt−PERIOD_US| ≤ PERIOD_TOL: duty_pct←min(hi_cnt,100), level updated, duty_valid pulse, pwm_active←1, state→TRACK.
    - Otherwise: period_err pulse, outputs held, pwm_active←0, state→ARMED. The new period still starts on that edge.
  - Any state except IDLE, when per_cnt reaches TIMEOUT_US: stalled.
    - duty_pct←100 and level←4 if s2=1; duty_pct←0 and level←0 if s2=0.
    - One duty_valid pulse, pwm_active←0, state→IDLE.
  - IDLE while the line is constantly high or low since reset: no outputs are produced. Timeout is not armed until the first rise.
- Quantisation of duty_pct:
  - <13 → 0; 13..37 → 1; 38..62 → 2; 63..87 → 3; ≥88 → 4.
- Simultaneous events: rise and timeout in the same cycle resolve in favour of rise (timeout ignored).
- Outputs are registered.
- duty_pct and level hold their value between updates.

Optional Feature:
- Macro: PWM_DUTY_FILTER_EN.
- Defined:
  - level changes only after two consecutive valid periods quantise to the same new level.
  - duty_valid pulses only when level is actually updated; duty_pct is updated together with it.
  - A period_err or timeout clears the pending candidate.
  - Timeout still updates immediately.
- Undefined: every valid period updates the outputs and pulses duty_valid, as described in Behaviour.

Test Plan:
- Stream of 100-cycle periods, 75 cycles high → after the second rise, duty_valid every 100 cycles with duty_pct=75, level=3, pwm_active=1.
- Ramp of 75 %→50 %→25 % periods (33 each), then line held low → level 3→2→1 transitions. 250 cycles after the last rise: duty_pct=0, level=0, one duty_valid, pwm_active=0.
- Line held high for 300 cycles after one rise → stalled at cycle 250: duty_pct=100, level=4, FSM IDLE.
- Period 120 cycles (50 high) inserted in a 50 % stream → period_err pulse, no duty_valid, pwm_active=0. Next 100-cycle period gives duty_valid with duty_pct=50. Periods of 98 and 102 are accepted.
- Reset asserted mid-period (cycle 40 of a 75 % period) → outputs 0 immediately and asynchronously. After release, the first rise gives no duty_valid; the second rise gives duty_pct=75.
- With PWM_DUTY_FILTER_EN: one 25 % period inside a 75 % stream → level stays 3 and no duty_valid for that period. Two consecutive 25 % periods → level=1 on the second.
